// File: rtl/aurora_hls_link_ctrl.sv
// aurora_hls_link_ctrl: Aurora bring-up FSM with timeout/retry, link-drop counting and NFC XON/XOFF requests.
module aurora_hls_link_ctrl #(
  parameter int RESET_CYCLES   = 64,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_RETRIES    = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] aurora_status,
  input  logic        fifo_rx_almost_full,
  output logic        core_reset,
  output logic        tx_enable,
  output logic        link_up,
  output logic        link_failed,
  output logic        nfc_valid,
  output logic        nfc_xoff,
  input  logic        nfc_ready,
  output logic [7:0]  retry_count,
  output logic [31:0] link_drop_count
);
  localparam int MAXC = (RESET_CYCLES > TIMEOUT_CYCLES) ? RESET_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] RC_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] MAX_R = 8'(MAX_RETRIES);
  typedef enum logic [1:0] {RESET_CORE, WAIT_UP, UP, FAILED} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] retry_q, retry_d;
  logic [31:0] drop_q, drop_d;
  logic valid_q, valid_d, xoff_q, xoff_d, sent_q, sent_d, want_q, want_d;
  logic ok, rc_done, timeout, stay_up;
  assign ok = aurora_status == 13'h11ff;
  assign rc_done = state_q == RESET_CORE && cnt_q == RC_LAST;
  assign timeout = state_q == WAIT_UP && !ok && cnt_q == TO_LAST;
  assign stay_up = state_q == UP && ok;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RESET_CORE;
      cnt_q   <= '0;
      retry_q <= '0;
      drop_q  <= '0;
      valid_q <= 1'b0;
      xoff_q  <= 1'b0;
      sent_q  <= 1'b0;
      want_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      xoff_q  <= xoff_d;
      sent_q  <= sent_d;
      want_q  <= want_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET_CORE: state_d = rc_done ? WAIT_UP : RESET_CORE;
      WAIT_UP:    state_d = ok ? UP : !timeout ? WAIT_UP : (retry_q < MAX_R) ? RESET_CORE : FAILED;
      UP:         state_d = ok ? UP : RESET_CORE;
      default:    state_d = FAILED;
    endcase
  end
  always_comb begin
    core_reset  = state_q == RESET_CORE || state_q == FAILED;
    tx_enable   = state_q == UP;
    link_up     = state_q == UP;
    link_failed = state_q == FAILED;
  end
  // The cycle counter restarts on every state change and only runs in the two timed states.
  always_comb begin
    cnt_d   = (state_d != state_q || state_q == UP || state_q == FAILED) ? '0 : cnt_q + 1'b1;
    retry_d = (timeout && retry_q != 8'hff) ? retry_q + 1'b1 : retry_q;
    drop_d  = (state_q == UP && !ok) ? drop_q + 1'b1 : drop_q;
  end
  // A pending request is frozen until accepted; leaving UP voids it along with the sent type.
  always_comb begin
    want_d  = stay_up && fifo_rx_almost_full;
    valid_d = valid_q;
    xoff_d  = xoff_q;
    sent_d  = sent_q;
    if (!stay_up) begin
      valid_d = 1'b0;
      xoff_d  = 1'b0;
      sent_d  = 1'b0;
    end else if (valid_q) begin
      valid_d = !nfc_ready;
      sent_d  = nfc_ready ? xoff_q : sent_q;
    end else if (want_q != sent_q) begin
      valid_d = 1'b1;
      xoff_d  = want_q;
    end
  end
  assign nfc_valid       = valid_q;
  assign nfc_xoff        = xoff_q;
  assign retry_count     = retry_q;
  assign link_drop_count = drop_q;
endmodule
